// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block-wide data memory between
// two cache controllers (port 0, port 1). Each grant is held stable until the
// memory signals completion.
//
// Ports (k = 0, 1):
//   clk_i, reset_i          clock, synchronous active-high reset
//   rk_read_i / rk_wr_i     block read / write-back request (both high = write)
//   rk_address_i            block address (AW bits)
//   rk_write_data_i         block write data (BW bits)
//   rk_busywait_o           request pending and not yet completed
//   rk_read_data_o          memory read block while port k is granted, else 0
//   rk_read_done_o          read completion pulse for port k
//   rk_write_done_o         write completion pulse for port k
//   m_read_o / m_wr_o       registered memory strobes
//   m_address_o             latched block address
//   m_write_data_o          latched block write data
//   m_busywait_i            memory busy (informational)
//   m_read_data_i           memory read block
//   m_read_done_i           memory read-complete pulse
//   m_write_done_i          memory write-complete pulse
module mem_arbiter #(
    parameter int BLOCK_SIZE   = 2,
    parameter int LINE_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    localparam int unsigned BW = (2 ** BLOCK_SIZE) * LINE_SIZE,
    localparam int unsigned AW = ADDRESS_SIZE - BLOCK_SIZE - 2
) (
    input  logic          clk_i,
    input  logic          reset_i,

    input  logic          r0_read_i,
    input  logic          r0_wr_i,
    input  logic [AW-1:0] r0_address_i,
    input  logic [BW-1:0] r0_write_data_i,
    output logic          r0_busywait_o,
    output logic [BW-1:0] r0_read_data_o,
    output logic          r0_read_done_o,
    output logic          r0_write_done_o,

    input  logic          r1_read_i,
    input  logic          r1_wr_i,
    input  logic [AW-1:0] r1_address_i,
    input  logic [BW-1:0] r1_write_data_i,
    output logic          r1_busywait_o,
    output logic [BW-1:0] r1_read_data_o,
    output logic          r1_read_done_o,
    output logic          r1_write_done_o,

    output logic          m_read_o,
    output logic          m_wr_o,
    output logic [AW-1:0] m_address_o,
    output logic [BW-1:0] m_write_data_o,
    input  logic          m_busywait_i,
    input  logic [BW-1:0] m_read_data_i,
    input  logic          m_read_done_i,
    input  logic          m_write_done_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY0   = 2'd1,
        ST_BUSY1   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic          last_grant_q, last_grant_d;
    logic          m_read_d, m_wr_d;
    logic [AW-1:0] addr_d;
    logic [BW-1:0] wdata_d;

    logic req0, req1;
    logic grant0, grant1;
    logic busy0, busy1;
    logic done_match;

    // Memory busy is not needed: completion is signalled by the done pulses.
    logic unused_busywait;
    assign unused_busywait = m_busywait_i;

    assign req0 = r0_read_i | r0_wr_i;
    assign req1 = r1_read_i | r1_wr_i;

    // On a tie the port that did not win last time is granted.
    assign grant0 = req0 & (~req1 | last_grant_q);
    assign grant1 = req1 & (~req0 | ~last_grant_q);

    assign busy0 = (state_q == ST_BUSY0);
    assign busy1 = (state_q == ST_BUSY1);

    // Only the done pulse matching the latched op can end a transaction.
    assign done_match = op_wr_q ? m_write_done_i : m_read_done_i;

    // State register plus latched transaction and registered memory strobes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            op_wr_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            m_read_o       <= 1'b0;
            m_wr_o         <= 1'b0;
            m_address_o    <= '0;
            m_write_data_o <= '0;
        end else begin
            state_q        <= state_d;
            op_wr_q        <= op_wr_d;
            last_grant_q   <= last_grant_d;
            m_read_o       <= m_read_d;
            m_wr_o         <= m_wr_d;
            m_address_o    <= addr_d;
            m_write_data_o <= wdata_d;
        end
    end

    // Next-state, arbitration and next strobe values.
    always_comb begin
        state_d      = state_q;
        op_wr_d      = op_wr_q;
        last_grant_d = last_grant_q;
        m_read_d     = m_read_o;
        m_wr_d       = m_wr_o;
        addr_d       = m_address_o;
        wdata_d      = m_write_data_o;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                state_d  = ST_IDLE;
                m_read_d = 1'b0;
                m_wr_d   = 1'b0;
                if (grant0) begin
                    state_d      = ST_BUSY0;
                    op_wr_d      = r0_wr_i;
                    addr_d       = r0_address_i;
                    wdata_d      = r0_write_data_i;
                    last_grant_d = 1'b0;
                    m_read_d     = ~r0_wr_i;
                    m_wr_d       = r0_wr_i;
                end else if (grant1) begin
                    state_d      = ST_BUSY1;
                    op_wr_d      = r1_wr_i;
                    addr_d       = r1_address_i;
                    wdata_d      = r1_write_data_i;
                    last_grant_d = 1'b1;
                    m_read_d     = ~r1_wr_i;
                    m_wr_d       = r1_wr_i;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (done_match) begin
                    state_d  = ST_RELEASE;
                    m_read_d = 1'b0;
                    m_wr_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                m_read_d = 1'b0;
                m_wr_d   = 1'b0;
            end
        endcase
    end

    // Completion and read data reach only the granted requester.
    assign r0_read_done_o  = m_read_done_i  & busy0 & ~op_wr_q;
    assign r0_write_done_o = m_write_done_i & busy0 &  op_wr_q;
    assign r1_read_done_o  = m_read_done_i  & busy1 & ~op_wr_q;
    assign r1_write_done_o = m_write_done_i & busy1 &  op_wr_q;

    assign r0_read_data_o = busy0 ? m_read_data_i : '0;
    assign r1_read_data_o = busy1 ? m_read_data_i : '0;

    assign r0_busywait_o = req0 & ~(r0_read_done_o | r0_write_done_o);
    assign r1_busywait_o = req1 & ~(r1_read_done_o | r1_write_done_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: requesters replay transaction queues, a bench
// memory answers with random latency, and a transaction-level round-robin
// model predicts grant order, addresses and read data.
module tb_mem_arbiter;

    localparam int unsigned BW = 128;
    localparam int unsigned AW = 28;

    typedef struct {
        logic          prt;
        logic          wr;
        logic          both;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          r0_read_i, r0_wr_i, r1_read_i, r1_wr_i;
    logic [AW-1:0] r0_address_i, r1_address_i;
    logic [BW-1:0] r0_write_data_i, r1_write_data_i;
    logic          r0_busywait_o, r1_busywait_o;
    logic [BW-1:0] r0_read_data_o, r1_read_data_o;
    logic          r0_read_done_o, r0_write_done_o, r1_read_done_o, r1_write_done_o;
    logic          m_read_o, m_wr_o;
    logic [AW-1:0] m_address_o;
    logic [BW-1:0] m_write_data_o;
    logic          m_busywait_i;
    logic [BW-1:0] m_read_data_i;
    logic          m_read_done_i, m_write_done_i;

    mem_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .r0_read_i(r0_read_i), .r0_wr_i(r0_wr_i), .r0_address_i(r0_address_i),
        .r0_write_data_i(r0_write_data_i), .r0_busywait_o(r0_busywait_o),
        .r0_read_data_o(r0_read_data_o), .r0_read_done_o(r0_read_done_o),
        .r0_write_done_o(r0_write_done_o),
        .r1_read_i(r1_read_i), .r1_wr_i(r1_wr_i), .r1_address_i(r1_address_i),
        .r1_write_data_i(r1_write_data_i), .r1_busywait_o(r1_busywait_o),
        .r1_read_data_o(r1_read_data_o), .r1_read_done_o(r1_read_done_o),
        .r1_write_done_o(r1_write_done_o),
        .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_address_o(m_address_o),
        .m_write_data_o(m_write_data_o), .m_busywait_i(m_busywait_i),
        .m_read_data_i(m_read_data_i), .m_read_done_i(m_read_done_i),
        .m_write_done_i(m_write_done_i)
    );

    always #5 clk_i = ~clk_i;

    int   checks = 0;
    int   errors = 0;
    txn_t q0[$];
    txn_t q1[$];
    txn_t order[$];
    int   idx = 0;
    logic model_last = 1'b1;
    logic done_seen0 = 1'b0, done_seen1 = 1'b0;
    bit   spur_en = 1'b0, mem_stall = 1'b0;
    bit   mem_active = 1'b0;
    int   mem_cnt = 0;
    bit   prev_valid = 1'b0, prev_high = 1'b0, prev_done = 1'b0, prev_req = 1'b0;
    logic [BW-1:0] mem     [16];
    logic [BW-1:0] exp_mem [16];

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic txn_t mk(logic p, logic w, logic b, int a, logic [BW-1:0] d);
        txn_t t;
        t.prt = p; t.wr = w; t.both = b; t.addr = AW'(a); t.data = d;
        return t;
    endfunction

    // Bench memory: random latency, optional wrong-type / idle done pulses.
    task automatic mem_step();
        m_read_done_i  = 1'b0;
        m_write_done_i = 1'b0;
        m_busywait_i   = 1'b0;
        m_read_data_i  = rand_block();
        if (m_read_o === 1'b1 || m_wr_o === 1'b1) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt    = $urandom_range(0, 3);
            end
            if (mem_cnt == 0 && !mem_stall) begin
                mem_active = 1'b0;
                if (m_wr_o === 1'b1) begin
                    mem[m_address_o[3:0]] = m_write_data_o;
                    m_write_done_i = 1'b1;
                end else begin
                    m_read_data_i = mem[m_address_o[3:0]];
                    m_read_done_i = 1'b1;
                end
            end else begin
                if (mem_cnt > 0) mem_cnt--;
                m_busywait_i = 1'b1;
                if (spur_en && $urandom_range(0, 2) == 0) begin
                    if (m_wr_o === 1'b1) m_read_done_i = 1'b1;
                    else                 m_write_done_i = 1'b1;
                end
            end
        end else begin
            mem_active = 1'b0;
            if (spur_en && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) m_read_done_i  = 1'b1;
                else                           m_write_done_i = 1'b1;
            end
        end
    endtask

    // Requesters retire their head entry on the cycle after its done pulse.
    task automatic drive_req();
        if (done_seen0 && q0.size() > 0) void'(q0.pop_front());
        if (done_seen1 && q1.size() > 0) void'(q1.pop_front());
        done_seen0 = 1'b0;
        done_seen1 = 1'b0;
        if (q0.size() > 0) begin
            r0_read_i = ~q0[0].wr | q0[0].both; r0_wr_i = q0[0].wr;
            r0_address_i = q0[0].addr; r0_write_data_i = q0[0].data;
        end else begin
            r0_read_i = 1'b0; r0_wr_i = 1'b0; r0_address_i = '0; r0_write_data_i = '0;
        end
        if (q1.size() > 0) begin
            r1_read_i = ~q1[0].wr | q1[0].both; r1_wr_i = q1[0].wr;
            r1_address_i = q1[0].addr; r1_write_data_i = q1[0].data;
        end else begin
            r1_read_i = 1'b0; r1_wr_i = 1'b0; r1_address_i = '0; r1_write_data_i = '0;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the transaction model.
    task automatic monitor();
        txn_t t;
        bit   hi, comp;
        logic erd0, ewr0, erd1, ewr1, req0, req1;
        hi   = (m_read_o === 1'b1) || (m_wr_o === 1'b1);
        comp = 1'b0;
        erd0 = 1'b0; ewr0 = 1'b0; erd1 = 1'b0; ewr1 = 1'b0;
        req0 = r0_read_i | r0_wr_i;
        req1 = r1_read_i | r1_wr_i;
        checks++;
        if ((m_read_o & m_wr_o) !== 1'b0) begin
            errors++; $display("FAIL strobe_excl: rd=%b wr=%b, required not both", m_read_o, m_wr_o);
        end
        if (prev_valid) begin
            checks++;
            if (prev_done) begin
                if (hi !== 1'b0) begin errors++; $display("FAIL release_gap: strobe=%b required 0", hi); end
            end else if (prev_high) begin
                if (hi !== 1'b1) begin errors++; $display("FAIL strobe_hold: strobe=%b required 1", hi); end
            end else if (hi !== prev_req) begin
                errors++; $display("FAIL grant_latency: strobe=%b required %b", hi, prev_req);
            end
        end
        if (hi) begin
            checks++;
            if (idx >= order.size()) begin
                errors++; $display("FAIL unexpected_grant: strobe high, required no transaction");
            end else begin
                t = order[idx];
                if ({m_read_o, m_wr_o} !== {~t.wr, t.wr}) begin
                    errors++; $display("FAIL strobe_type: rd/wr=%b%b required %b%b", m_read_o, m_wr_o, ~t.wr, t.wr);
                end
                checks++;
                if (m_address_o !== t.addr) begin
                    errors++; $display("FAIL address: got %h required %h", m_address_o, t.addr);
                end
                if (t.wr) begin
                    checks++;
                    if (m_write_data_o !== t.data) begin
                        errors++; $display("FAIL write_data: got %h required %h", m_write_data_o, t.data);
                    end
                end
                comp = t.wr ? (m_write_done_i === 1'b1) : (m_read_done_i === 1'b1);
                if (t.prt == 1'b0) begin erd0 = comp & ~t.wr; ewr0 = comp & t.wr; end
                else               begin erd1 = comp & ~t.wr; ewr1 = comp & t.wr; end
                checks++;
                if ((t.prt ? r0_read_data_o : r1_read_data_o) !== '0) begin
                    errors++; $display("FAIL ungranted_data: port %0d data nonzero, required 0", ~t.prt);
                end
                if (comp) begin
                    if (!t.wr) begin
                        checks++;
                        if ((t.prt ? r1_read_data_o : r0_read_data_o) !== exp_mem[t.addr[3:0]]) begin
                            errors++;
                            $display("FAIL read_data: port %0d got %h required %h", t.prt,
                                     (t.prt ? r1_read_data_o : r0_read_data_o), exp_mem[t.addr[3:0]]);
                        end
                    end else begin
                        exp_mem[t.addr[3:0]] = t.data;
                    end
                    if (t.prt) done_seen1 = 1'b1; else done_seen0 = 1'b1;
                    idx++;
                end
            end
        end else begin
            checks++;
            if (r0_read_data_o !== '0 || r1_read_data_o !== '0) begin
                errors++; $display("FAIL idle_data: r0=%h r1=%h required 0", r0_read_data_o, r1_read_data_o);
            end
        end
        checks++;
        if ({r0_read_done_o, r0_write_done_o, r1_read_done_o, r1_write_done_o} !== {erd0, ewr0, erd1, ewr1}) begin
            errors++;
            $display("FAIL done_pulses: got %b%b%b%b required %b%b%b%b", r0_read_done_o, r0_write_done_o,
                     r1_read_done_o, r1_write_done_o, erd0, ewr0, erd1, ewr1);
        end
        checks++;
        if ({r0_busywait_o, r1_busywait_o} !== {req0 & ~(erd0 | ewr0), req1 & ~(erd1 | ewr1)}) begin
            errors++;
            $display("FAIL busywait: got %b%b required %b%b", r0_busywait_o, r1_busywait_o,
                     req0 & ~(erd0 | ewr0), req1 & ~(erd1 | ewr1));
        end
        prev_valid = 1'b1;
        prev_high  = hi;
        prev_done  = comp;
        prev_req   = req0 | req1;
    endtask

    task automatic cycle();
        @(negedge clk_i);
        mem_step();
        drive_req();
        #1;
        monitor();
    endtask

    // Round-robin at transaction level: ties go to the port not served last.
    task automatic build_order();
        txn_t a[$];
        txn_t b[$];
        logic last;
        a = q0; b = q1; last = model_last;
        order.delete();
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() > 0 && (b.size() == 0 || last == 1'b1)) begin
                order.push_back(a.pop_front()); last = 1'b0;
            end else begin
                order.push_back(b.pop_front()); last = 1'b1;
            end
        end
        model_last = last;
        idx = 0;
    endtask

    task automatic run_queues(string name);
        build_order();
        for (int n = 0; n < 600; n++) begin
            if (idx == order.size() && q0.size() == 0 && q1.size() == 0) break;
            cycle();
        end
        checks++;
        if (idx != order.size() || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: completed %0d required %0d", name, idx, order.size());
        end
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        q0.delete(); q1.delete(); order.delete();
        idx = 0; done_seen0 = 1'b0; done_seen1 = 1'b0; mem_active = 1'b0;
        drive_req();
        m_read_done_i = 1'b0; m_write_done_i = 1'b0; m_busywait_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        m_read_data_i = rand_block() | 128'h1;
        m_read_done_i = 1'b1;
        #1;
        checks++;
        if ({m_read_o, m_wr_o} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b%b required 00", m_read_o, m_wr_o);
        end
        checks++;
        if (m_address_o !== '0 || m_write_data_o !== '0) begin
            errors++; $display("FAIL reset_addr_data: addr=%h data=%h required 0", m_address_o, m_write_data_o);
        end
        checks++;
        if ({r0_read_done_o, r0_write_done_o, r1_read_done_o, r1_write_done_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_dones: got %b%b%b%b required 0000", r0_read_done_o,
                               r0_write_done_o, r1_read_done_o, r1_write_done_o);
        end
        checks++;
        if (r0_read_data_o !== '0 || r1_read_data_o !== '0 || {r0_busywait_o, r1_busywait_o} !== 2'b00) begin
            errors++; $display("FAIL reset_outputs: r0d=%h r1d=%h bw=%b%b required 0", r0_read_data_o,
                               r1_read_data_o, r0_busywait_o, r1_busywait_o);
        end
        m_read_done_i = 1'b0;
        model_last = 1'b1;
        prev_valid = 1'b1; prev_high = 1'b0; prev_done = 1'b0; prev_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_read();
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 1, '0));
        run_queues("single_read");
    endtask

    task automatic test_simultaneous();
        do_reset();
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 2, '0));
        q1.push_back(mk(1'b1, 1'b0, 1'b0, 3, '0));
        run_queues("simultaneous");
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b0, 1'b0, 1'b0, 4 + i, '0));
            q1.push_back(mk(1'b1, 1'b0, 1'b0, 8 + i, '0));
        end
        run_queues("round_robin");
    endtask

    task automatic test_writeback_fetch();
        do_reset();
        q1.push_back(mk(1'b1, 1'b1, 1'b1, 5, 128'h32));
        run_queues("writeback");
        checks++;
        if (mem[5] !== 128'h32) begin
            errors++; $display("FAIL writeback_mem: block5=%h required %h", mem[5], 128'h32);
        end
        q1.push_back(mk(1'b1, 1'b0, 1'b0, 9, '0));
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 5, '0));
        run_queues("fetch");
    endtask

    task automatic test_spurious();
        spur_en = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 6, '0));
        q1.push_back(mk(1'b1, 1'b1, 1'b0, 7, rand_block()));
        q1.push_back(mk(1'b1, 1'b0, 1'b0, 7, '0));
        run_queues("spurious");
        spur_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        q1.push_back(mk(1'b1, 1'b1, 1'b0, 11, rand_block()));
        build_order();
        mem_stall = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (m_wr_o === 1'b1) break;
        end
        cycle();
        checks++;
        if (m_wr_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: m_wr_o=%b required 1", m_wr_o);
        end
        do_reset();
        mem_stall = 1'b0;
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 12, '0));
        q1.push_back(mk(1'b1, 1'b0, 1'b0, 13, '0));
        run_queues("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            int n0, n1;
            spur_en = ($urandom_range(0, 1) == 1);
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(0, 5);
            for (int i = 0; i < n0; i++)
                q0.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                $urandom_range(0, 15), rand_block()));
            for (int i = 0; i < n1; i++)
                q1.push_back(mk(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                $urandom_range(0, 15), rand_block()));
            run_queues("random");
        end
        spur_en = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        r0_read_i = 1'b0; r0_wr_i = 1'b0; r0_address_i = '0; r0_write_data_i = '0;
        r1_read_i = 1'b0; r1_wr_i = 1'b0; r1_address_i = '0; r1_write_data_i = '0;
        m_busywait_i = 1'b0; m_read_data_i = '0; m_read_done_i = 1'b0; m_write_done_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = rand_block();
            exp_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk_i);
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_writeback_fetch();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single block-wide data memory between two cache controllers, e.g. an instruction cache on port 0 and a data cache on port 1. It sits between the caches' memory-side ports (read/write request, block address, block write data) and the memory's request/busywait/done interface. It grants one requester at a time with round-robin priority and holds the granted transaction stable until the memory signals completion. It forwards read data and completion pulses only to the granted requester.

## Interface
Parameters:
- BLOCK_SIZE, 2, log2 of words per block
- LINE_SIZE, 32, word width in bits
- ADDRESS_SIZE, 32, byte-address width
- Derived widths: BW = 2**BLOCK_SIZE*LINE_SIZE (128); AW = ADDRESS_SIZE-BLOCK_SIZE-2 (28)

Ports (k = 0, 1, per requester):
- clk_i  in  1  clock; everything updates on its rising edge
- reset_i  in  1  synchronous, active-high reset
- rk_read_i  in  1  block read request
- rk_wr_i  in  1  block write (write-back) request
- rk_address_i  in  AW  block address
- rk_write_data_i  in  BW  block write data
- rk_busywait_o  out  1  request pending and not yet completed
- rk_read_data_o  out  BW  read block; zero unless granted
- rk_read_done_o  out  1  read completion pulse
- rk_write_done_o  out  1  write completion pulse
- m_read_o  out  1  memory read strobe
- m_wr_o  out  1  memory write strobe
- m_address_o  out  AW  memory block address
- m_write_data_o  out  BW  memory write data
- m_busywait_i  in  1  memory busy; informational only
- m_read_data_i  in  BW  memory read block
- m_read_done_i  in  1  memory read-complete pulse
- m_write_done_i  in  1  memory write-complete pulse

## Operation
- States:
  - IDLE
  - BUSY0, BUSY1: transaction for requester k in flight
  - RELEASE: memory strobes low for one cycle
- Registers:
  - state
  - op (read/write)
  - latched address and write data
  - last_grant: 1 after reset, so port 0 wins the first tie
- Request: reqk = rk_read_i | rk_wr_i.
  - If both rk_read_i and rk_wr_i are high, the request is treated as a write.
- Arbitration point: IDLE and RELEASE.
  - If exactly one reqk is high, grant k.
  - If both are high, grant the port that is not last_grant.
  - On a grant: latch op, address and write data from rk_*; go to BUSYk; set last_grant = k.
  - With no request, go to or stay in IDLE.
- m_read_o / m_wr_o are registered:
  - high in BUSYk per the latched op;
  - low in IDLE and RELEASE.
- m_address_o and m_write_data_o are driven from the latched registers and held constant for the whole of BUSYk.
- Completion in BUSYk:
  - For a read op, m_read_done_i ends the transaction and causes BUSYk→RELEASE.
  - For a write op, m_write_done_i does the same.
  - A done pulse of the opposite type, or any done outside BUSY, is ignored.
- Combinational outputs:
  - rk_read_done_o = m_read_done_i & state==BUSYk & op==read
  - rk_write_done_o: same form, for write
  - rk_read_data_o = m_read_data_i when state==BUSYk, else 0
  - rk_busywait_o = reqk & ~(rk_read_done_o | rk_write_done_o)
- A requester must update or drop its request on the edge following its done pulse. A request still held at RELEASE is re-arbitrated as a new request. A write-back followed by a fetch may therefore be interleaved with the other port's transaction; this is permitted.
- Reset (any state, including mid-transaction):
  - state = IDLE, last_grant = 1
  - m_read_o = m_wr_o = 0
  - m_address_o = 0, m_write_data_o = 0
  - All done outputs = 0; rk_read_data_o = 0
  - The in-flight transaction is abandoned; memory is reset on the same reset_i.

## Timing
- Grant latency:
  - request high during cycle c (IDLE) → state BUSYk and memory strobe high from cycle c+1;
  - rk_busywait_o is high from cycle c.
- Done sampled in cycle d (combinational pass-through) → RELEASE in cycle d+1 with strobes low.
  - If a request is pending in d+1, the next strobe is high in d+2.
  - Exactly one strobe-low cycle separates consecutive transactions.
- Strobe, address and data are stable from the grant edge through the done cycle inclusive.
- Both strobes are never high simultaneously.
- A losing requester sees rk_busywait_o=1 continuously until its own done pulse.
- Arbiter overhead per transaction is 2 cycles (grant + RELEASE) on top of memory latency.

## Test plan
- Single read:
  - Stimulus: r0_read_i=1, r0_address_i=28'h1 while idle.
  - m_read_o=1 and m_address_o=1 on the next cycle, and stay stable.
  - The memory done pulse produces r0_read_done_o=1 and r0_read_data_o equal to memory block 1.
  - r1 outputs stay 0; m_read_o=0 in the following cycle.
- Simultaneous requests after reset:
  - Stimulus: r0 read of block 2 and r1 read of block 3 in the same cycle.
  - Port 0 is served first, then port 1 after exactly one strobe-low cycle.
  - r1_busywait_o stays high throughout until its own done pulse.
- Round-robin fairness:
  - Stimulus: both ports hold requests continuously for 4 transactions.
  - Grants alternate 0,1,0,1; no port is served twice in a row.
- Write-back then fetch:
  - Stimulus: r1_wr_i=1, block 5, data 128'h32; after the write done, r1 switches to a read of block 9 while r0 requests a read.
  - Memory block 5 = 128'h32.
  - r0 is served before r1's fetch, since last_grant=1.
- Spurious done:
  - m_write_done_i pulsed during a read, and in IDLE.
  - No done output asserts; state and strobes are unchanged.
- Reset mid-transaction:
  - reset_i=1 for one cycle during BUSY1.
  - Next cycle: IDLE, all strobes and done outputs 0.
  - A simultaneous request then grants port 0 first.
